// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
//
// Multiplies produce the full 2*XLEN product at accept and present the selected half one
// edge later. Divides and remainders run on an iterative radix-2 restoring divider, one
// quotient bit per cycle, followed by a sign-fixup cycle. Division by zero and signed
// overflow are resolved at accept without iterating.
//
// Ports:
//   CLK         clock, rising-edge active
//   RESET       synchronous active-high reset
//   in_valid    operation request
//   in_ready    unit can accept (IDLE and RESET low)
//   in_op       RISC-V funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   in_a        rs1 value
//   in_b        rs2 value
//   flush       abort any in-flight operation; result is discarded
//   out_valid   result available (DONE)
//   out_ready   consumer takes the result
//   out_result  result, held stable while out_valid is high
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;

    logic              accept;
    logic              mul_a_signed, mul_b_signed, div_signed;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [XLEN-1:0]   mul_res;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_by_zero, div_ovf;
    logic [XLEN-1:0]   div_special;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              q_bit;

    // Handshake outputs depend only on registered state (and RESET).
    assign in_ready   = (state_q == StIdle) && !RESET;
    assign out_valid  = (state_q == StDone);
    assign out_result = result_q;
    assign accept     = in_valid && in_ready && !flush;

    // Multiply: sign-extend both operands to 2*XLEN so a single unsigned multiply yields the
    // correct low 2*XLEN bits for every signedness combination.
    assign mul_a_signed = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
    assign mul_b_signed = (in_op[1:0] == 2'b01);
    assign mul_a   = {{XLEN{mul_a_signed & in_a[XLEN-1]}}, in_a};
    assign mul_b   = {{XLEN{mul_b_signed & in_b[XLEN-1]}}, in_b};
    assign product = mul_a * mul_b;
    assign mul_res = (in_op[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // Divide operand conditioning. DIV/REM are signed (funct3[0] == 0).
    assign div_signed  = !in_op[0];
    assign a_neg       = div_signed & in_a[XLEN-1];
    assign b_neg       = div_signed & in_b[XLEN-1];
    assign abs_a       = a_neg ? -in_a : in_a;
    assign abs_b       = b_neg ? -in_b : in_b;
    assign div_by_zero = (in_b == '0);
    assign div_ovf     = div_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

    always_comb begin
        div_special = '0;
        if (div_by_zero) begin
            div_special = in_op[1] ? in_a : '1;
        end else begin
            div_special = in_op[1] ? '0 : in_a;
        end
    end

    // Restoring step: quot_q doubles as the dividend shift register, its MSB feeds the
    // partial remainder while quotient bits shift in at the LSB.
    assign rem_shift = {rem_q, quot_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_q};
    assign q_bit     = !rem_diff[XLEN];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        if (flush) begin
            // Abort: back to IDLE, out_result keeps its last committed value.
            state_d = StIdle;
            count_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!in_op[2]) begin
                            result_d = mul_res;
                            state_d  = StDone;
                        end else if (div_by_zero || div_ovf) begin
                            result_d = div_special;
                            state_d  = StDone;
                        end else begin
                            quot_d     = abs_a;
                            rem_d      = '0;
                            divisor_d  = abs_b;
                            count_d    = CntW'(XLEN);
                            is_rem_d   = in_op[1];
                            neg_quot_d = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            state_d    = StDiv;
                        end
                    end
                end
                StDiv: begin
                    rem_d   = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    quot_d  = {quot_q[XLEN-2:0], q_bit};
                    count_d = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (is_rem_q) begin
                        result_d = neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        result_d = neg_quot_q ? -quot_q : quot_q;
                    end
                    state_d = StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            count_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle RV32M/RV64M multiply-divide unit for the EX stage. It supersedes the combinational multiply/divide paths of the single-cycle ALU: multiply has registered one-cycle latency, and divide/remainder runs on an iterative radix-2 restoring divider. It uses a valid/ready handshake so the pipeline can stall EX while a divide is in flight. The ALU keeps ADD through SLT and forwarding; the decoder routes all M-extension ops here.

## Interface
- XLEN, 32: operand/result width; legal values 32, 64.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE with RESET low.
- in_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 value.
- in_b  in  XLEN  rs2 value.
- flush  in  1  abort in-flight op (branch mispredict/trap).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.

## Operation
- States: IDLE, DIV, FIX, DONE.
- Accept occurs on an edge with in_valid & in_ready. Operands, op, and sign flags are latched at accept; later input changes are ignored.
- Multiply ops (in_op[2]=0): full 2·XLEN product computed and registered at accept, then IDLE→DONE.
  - MUL = product[XLEN-1:0].
  - MULH = high half of signed×signed.
  - MULHSU = high half of signed rs1 × unsigned rs2.
  - MULHU = high half of unsigned×unsigned.
  - High half is product[2XLEN-1:XLEN].
- Divide ops, special cases, resolved at accept with IDLE→DONE:
  - b=0: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow (a=most-negative, b=−1): DIV = a; REM = 0.
- Divide ops, normal case: at accept, take absolute values for signed ops, clear remainder, load counter = XLEN, then IDLE→DIV.
  - DIV: one quotient bit per cycle (shift remainder left with next dividend bit; subtract divisor if it does not go negative); counter decrements. When the counter reaches 0, DIV→FIX.
  - FIX: negate quotient if signs differ (DIV only); negate remainder if dividend negative (REM only). Then FIX→DONE.
- DONE: out_valid=1 and out_result held stable until an edge with out_ready=1, then →IDLE. No back-to-back overlap: accept is never possible in DONE.
- flush (any state, RESET low): next edge →IDLE, out_valid=0, result discarded. flush with in_valid in IDLE: op is not accepted. flush has priority over accept and over out_ready.
- RESET (any state, including mid-divide): next edge →IDLE, counter 0, out_valid 0, out_result 0. RESET has priority over flush.

## Timing
- Reset values: out_valid 0, out_result 0, in_ready 0 while RESET high and 1 in the first cycle after.
- Latency is accept edge to first cycle with out_valid=1:
  - Multiply and divide special cases: 1 edge.
  - Normal divide: XLEN+2 edges (34 for XLEN=32).
- Throughput: one op outstanding at a time. The earliest next accept is the edge after the out_ready handshake edge (in_ready rises in IDLE).
- out_result changes only on the edge that enters DONE or on RESET.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Test plan
- Reset mid-divide: DIVU 100/7, assert RESET at cycle 10 → next cycle out_valid=0, out_result=0, in_ready=1 after RESET drops; no result ever appears.
- Multiply set: MUL 0xFFFFFFFF×2 → 0xFFFFFFFE; MULH −1×−1 → 0; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF; each has out_valid one edge after accept.
- Signed divide: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; out_valid exactly 34 edges after accept, in_ready low throughout.
- Special cases: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM same → 0; each in 1 edge.
- Backpressure and flush: hold out_ready=0 for 5 cycles after DONE → out_result stable, in_ready=0; separately, flush at divide cycle 12 → IDLE next edge, a following MUL 3×4 returns 12.
- Random regression against a reference model, 10k ops per XLEN (32, 64), with random in_valid/out_ready/flush.
